// File: rtl/fifo_to_pkt.sv
// fifo_to_pkt: pops one 144-bit flow descriptor per frame from a non-FWFT FIFO
// and streams an Ethernet/IPv4/L4 frame as 64-bit beats (byte 0 in the MSBs)
// over a valid/ready handshake. Keeps a wrapping count of completed frames.
module fifo_to_pkt #(
   parameter int          FIFO_DATA_WIDTH = 144,
   parameter int          DATA_WIDTH      = 64,
   parameter logic [47:0] SRC_MAC         = 48'h00_0A_35_00_00_01,
   parameter logic [47:0] DST_MAC         = 48'h00_0A_35_00_00_02,
   parameter int          MIN_LEN         = 60,
   parameter int          MAX_LEN         = 1514,
   parameter int          PKT_CNT_WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [FIFO_DATA_WIDTH-1:0] fifo_data,
   input  logic                       fifo_empty,
   output logic                       fifo_rd_en,
   input  logic                       enable,
   input  logic                       sw_rst,
   output logic [DATA_WIDTH-1:0]      tx_data,
   output logic [DATA_WIDTH/8-1:0]    tx_keep,
   output logic                       tx_valid,
   output logic                       tx_last,
   input  logic                       tx_ready,
   output logic [PKT_CNT_WIDTH-1:0]   pkt_count,
   output logic                       busy
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_POP  = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_CALC = 3'd3;
   localparam logic [2:0] S_SEND = 3'd4;

   logic [2:0]   state;
   logic [7:0]   beat_cnt;
   logic [10:0]  len_q;
   logic [31:0]  sip_q;
   logic [31:0]  dip_q;
   logic [15:0]  sport_q;
   logic [15:0]  dport_q;
   logic [7:0]   proto_q;
   logic [15:0]  csum_q;

   logic [15:0]  tot_len;
   logic [15:0]  l4_len;
   logic [15:0]  csum_next;
   logic [15:0]  csum_sel;
   logic [383:0] hdr;
   logic [7:0]   last_beat;
   logic [7:0]   nxt_beat;
   logic         nxt_is_last;
   logic         unused_desc;

   // Low descriptor bits carry nothing for this block.
   assign unused_desc = ^fifo_data[23:0];

   assign busy = (state != S_IDLE);

   function automatic logic [10:0] clamp_len(input logic [15:0] len);
      if (len < 16'(MIN_LEN)) return 11'(MIN_LEN);
      if (len > 16'(MAX_LEN)) return 11'(MAX_LEN);
      return len[10:0];
   endfunction

   // Ones'-complement sum of the ten IPv4 header words with checksum = 0.
   function automatic logic [15:0] ip_csum(input logic [15:0] tot, input logic [15:0] id,
                                           input logic [7:0] proto, input logic [31:0] sip,
                                           input logic [31:0] dip);
      logic [19:0] s;
      s = 20'h04500 + {4'h0, tot} + {4'h0, id} + 20'h04000 + {4'h0, 8'h40, proto}
        + {4'h0, sip[31:16]} + {4'h0, sip[15:0]} + {4'h0, dip[31:16]} + {4'h0, dip[15:0]};
      s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
      s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
      return ~s[15:0];
   endfunction

   // Beats 0..5 carry the 42 header bytes; everything after is zero payload.
   function automatic logic [63:0] beat_word(input logic [383:0] h, input logic [7:0] idx);
      logic [383:0] sh;
      if (idx < 8'd6) begin
         sh = h << {idx[2:0], 6'b0};
         return sh[383:320];
      end
      return 64'h0;
   endfunction

   function automatic logic [7:0] keep_for(input logic is_last, input logic [2:0] rem);
      if (!is_last || rem == 3'd0) return 8'hFF;
      return ~(8'hFF >> rem);
   endfunction

   // Header fields, checksum and beat bookkeeping derived from captured descriptor.
   always_comb begin
      tot_len     = {5'b0, len_q} - 16'd14;
      l4_len      = {5'b0, len_q} - 16'd34;
      csum_next   = ip_csum(tot_len, pkt_count[15:0], proto_q, sip_q, dip_q);
      csum_sel    = (state == S_CALC) ? csum_next : csum_q;
      hdr         = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, tot_len, pkt_count[15:0],
                     16'h4000, 8'h40, proto_q, csum_sel, sip_q, dip_q, sport_q, dport_q,
                     l4_len, 16'h0000, 48'h0};
      last_beat   = 8'(({5'b0, len_q} + 16'd7) >> 3) - 8'd1;
      nxt_beat    = beat_cnt + 8'd1;
      nxt_is_last = (nxt_beat == last_beat);
   end

   // Descriptor capture and checksum register; pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (state == S_CAP) begin
         len_q   <= clamp_len(fifo_data[143:128]);
         sip_q   <= fifo_data[127:96];
         dip_q   <= fifo_data[95:64];
         sport_q <= fifo_data[63:48];
         dport_q <= fifo_data[47:32];
         proto_q <= fifo_data[31:24];
      end
      if (state == S_CALC) csum_q <= csum_next;
   end

   // Frame sequencer: pop, capture, checksum, then stream beats under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         fifo_rd_en <= 1'b0;
         beat_cnt   <= 8'd0;
         tx_valid   <= 1'b0;
         tx_last    <= 1'b0;
         tx_data    <= '0;
         tx_keep    <= '0;
         pkt_count  <= '0;
      end else if (sw_rst) begin
         state      <= S_IDLE;
         fifo_rd_en <= 1'b0;
         beat_cnt   <= 8'd0;
         tx_valid   <= 1'b0;
         tx_last    <= 1'b0;
         tx_data    <= '0;
         tx_keep    <= '0;
         pkt_count  <= '0;
      end else begin
         fifo_rd_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable && !fifo_empty) begin
                  fifo_rd_en <= 1'b1;
                  state      <= S_POP;
               end
            end
            S_POP: state <= S_CAP;
            S_CAP: begin
               beat_cnt <= 8'd0;
               state    <= S_CALC;
            end
            S_CALC: begin
               tx_valid <= 1'b1;
               tx_data  <= beat_word(hdr, 8'd0);
               tx_last  <= (last_beat == 8'd0);
               tx_keep  <= keep_for(last_beat == 8'd0, len_q[2:0]);
               state    <= S_SEND;
            end
            S_SEND: begin
               if (tx_ready) begin
                  if (tx_last) begin
                     tx_valid  <= 1'b0;
                     tx_last   <= 1'b0;
                     tx_data   <= '0;
                     tx_keep   <= '0;
                     pkt_count <= pkt_count + 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     beat_cnt <= nxt_beat;
                     tx_data  <= beat_word(hdr, nxt_beat);
                     tx_last  <= nxt_is_last;
                     tx_keep  <= keep_for(nxt_is_last, len_q[2:0]);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_to_pkt.sv
// tb_fifo_to_pkt: randomized bench for fifo_to_pkt with a non-FWFT FIFO model
// and a byte-level frame reference model; all checks go through chk().
module tb_fifo_to_pkt;

   localparam logic [47:0] SRC_MAC = 48'h00_0A_35_00_00_01;
   localparam logic [47:0] DST_MAC = 48'h00_0A_35_00_00_02;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sw_rst = 1'b0;
   logic         enable = 1'b0;
   logic [143:0] fifo_data = '0;
   logic         fifo_empty;
   logic         fifo_rd_en;
   logic [63:0]  tx_data;
   logic [7:0]   tx_keep;
   logic         tx_valid;
   logic         tx_last;
   logic         tx_ready = 1'b1;
   logic [31:0]  pkt_count;
   logic         busy;

   fifo_to_pkt dut (
      .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .enable(enable), .sw_rst(sw_rst), .tx_data(tx_data),
      .tx_keep(tx_keep), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
      .pkt_count(pkt_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic [143:0] mem [0:255];
   int           wr_ptr = 0;
   int           rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   beat_t        exp_q[$];
   logic [7:0]   fb[$];
   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc = 0;
   int           pop_cyc = 0;
   int           pops = 0;
   int           frames_done = 0;
   int           beat_idx = 0;
   int           last_nbeats = 0;
   logic [7:0]   last_keep = '0;
   logic [63:0]  cap [0:7];
   logic         lat_pending = 1'b0;
   logic         pop_pending = 1'b0;
   logic         stall_prev = 1'b0;
   logic         bp_on = 1'b0;
   beat_t        held;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_field(input logic [47:0] v, input int nbytes);
      for (int i = nbytes - 1; i >= 0; i--) fb.push_back(v[i*8 +: 8]);
   endtask

   // Reference: lay the frame out byte by byte, patch checksum, slice into beats.
   task automatic model_frame(input logic [143:0] d, input logic [15:0] id);
      int          len, fl, nb;
      logic [31:0] sum;
      logic [15:0] c;
      beat_t       e;
      len = int'(d[143:128]);
      fl  = (len < 60) ? 60 : ((len > 1514) ? 1514 : len);
      fb.delete();
      push_field(DST_MAC, 6);
      push_field(SRC_MAC, 6);
      push_field(48'h0800, 2);
      push_field(48'h45, 1);
      push_field(48'h00, 1);
      push_field(48'(fl - 14), 2);
      push_field(48'(id), 2);
      push_field(48'h4000, 2);
      push_field(48'h40, 1);
      push_field(48'(d[31:24]), 1);
      push_field(48'h0, 2);
      push_field(48'(d[127:96]), 4);
      push_field(48'(d[95:64]), 4);
      push_field(48'(d[63:48]), 2);
      push_field(48'(d[47:32]), 2);
      push_field(48'(fl - 34), 2);
      push_field(48'h0, 2);
      while (fb.size() < fl) fb.push_back(8'h00);
      sum = 0;
      for (int i = 14; i < 34; i += 2) sum += {16'h0, fb[i], fb[i+1]};
      while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
      c = ~sum[15:0];
      fb[24] = c[15:8];
      fb[25] = c[7:0];
      nb = (fl + 7) / 8;
      for (int b = 0; b < nb; b++) begin
         e.data = '0;
         e.keep = '0;
         for (int k = 0; k < 8; k++) begin
            if (b*8 + k < fl) begin
               e.data[63 - 8*k -: 8] = fb[b*8 + k];
               e.keep[7 - k] = 1'b1;
            end
         end
         e.last = (b == nb - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic monitor();
      beat_t e;
      cyc++;
      if (rst || sw_rst) begin
         exp_q.delete();
         frames_done = 0;
         beat_idx    = 0;
         stall_prev  = 1'b0;
         lat_pending = 1'b0;
         pop_pending = 1'b0;
         return;
      end
      chk("pkt_count", 64'(pkt_count), 64'(frames_done));
      if (stall_prev) begin
         chk("stall_valid", 64'(tx_valid), 64'd1);
         chk("stall_data", tx_data, held.data);
         chk("stall_keep", 64'(tx_keep), 64'(held.keep));
         chk("stall_last", 64'(tx_last), 64'(held.last));
      end else if (beat_idx > 0) begin
         chk("valid_hold", 64'(tx_valid), 64'd1);
      end
      if (fifo_rd_en) begin
         chk("pop_nonempty", 64'(fifo_empty), 64'd0);
         pops++;
         if (!fifo_empty) model_frame(mem[rd_ptr], 16'(frames_done));
         pop_cyc     = cyc;
         lat_pending = 1'b1;
      end
      pop_pending = fifo_rd_en;
      if (tx_valid && lat_pending) begin
         chk("latency", 64'(cyc - pop_cyc), 64'd3);
         lat_pending = 1'b0;
      end
      if (tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", tx_data, e.data);
            chk("beat_keep", 64'(tx_keep), 64'(e.keep));
            chk("beat_last", 64'(tx_last), 64'(e.last));
         end
         if (beat_idx < 8) cap[beat_idx] = tx_data;
         if (beat_idx == 2) chk("ip_id", 64'(tx_data[47:32]), 64'(frames_done[15:0]));
         beat_idx++;
         if (tx_last) begin
            last_nbeats = beat_idx;
            last_keep   = tx_keep;
            frames_done++;
            beat_idx    = 0;
         end
      end
      stall_prev = tx_valid && !tx_ready;
      held.data  = tx_data;
      held.keep  = tx_keep;
      held.last  = tx_last;
   endtask

   task automatic pre_edge();
      @(posedge clk);
      #1;
      if (pop_pending && rd_ptr != wr_ptr) begin
         fifo_data = mem[rd_ptr];
         rd_ptr++;
      end
      tx_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic cycle();
      pre_edge();
      @(negedge clk);
      monitor();
   endtask

   task automatic push_desc(input logic [143:0] d);
      mem[wr_ptr] = d;
      wr_ptr++;
   endtask

   function automatic logic [143:0] rand_desc(input int lo, input int hi);
      return {16'($urandom_range(hi, lo)), 32'($urandom()), 32'($urandom()),
              16'($urandom()), 16'($urandom()), 8'($urandom()), 24'($urandom())};
   endfunction

   task automatic drain(input int max_cyc);
      logic done;
      done = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         cycle();
         if (fifo_empty && !busy && !pop_pending && exp_q.size() == 0) done = 1'b1;
      end
      chk("drain_done", 64'(done), 64'd1);
   endtask

   initial begin
      int  base, p0;
      logic hit;

      // Reset state
      repeat (3) cycle();
      chk("rst_valid", 64'(tx_valid), 64'd0);
      chk("rst_last", 64'(tx_last), 64'd0);
      chk("rst_data", tx_data, 64'd0);
      chk("rst_keep", 64'(tx_keep), 64'd0);
      chk("rst_count", 64'(pkt_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      rst = 1'b0;
      cycle();

      // Single known descriptor
      push_desc({16'd64, 32'h0A000001, 32'h0A000002, 16'd1000, 16'd2000, 8'd17, 24'h0});
      enable = 1'b1;
      drain(200);
      chk("single_pops", 64'(pops), 64'd1);
      chk("single_beats", 64'(last_nbeats), 64'd8);
      chk("single_keep", 64'(last_keep), 64'hFF);
      chk("single_beat2", cap[2], 64'h0032_0000_4000_4011);
      chk("single_beat3", cap[3], 64'h26B9_0A00_0001_0A00);
      chk("single_beat4", cap[4], 64'h0002_03E8_07D0_001E);
      chk("single_count", 64'(pkt_count), 64'd1);

      // Length clamps
      push_desc(rand_desc(20, 20));
      drain(200);
      chk("min_beats", 64'(last_nbeats), 64'd8);
      chk("min_keep", 64'(last_keep), 64'hF0);
      push_desc(rand_desc(2000, 2000));
      drain(1000);
      chk("max_beats", 64'(last_nbeats), 64'd190);
      chk("max_keep", 64'(last_keep), 64'hC0);

      // Random descriptors under 50% backpressure
      bp_on = 1'b1;
      for (int i = 0; i < 20; i++) push_desc(rand_desc(0, 2100));
      drain(30000);
      bp_on = 1'b0;

      // Back-to-back preloaded descriptors after a soft reset
      enable = 1'b0;
      sw_rst = 1'b1;
      cycle();
      sw_rst = 1'b0;
      chk("swrst_count", 64'(pkt_count), 64'd0);
      p0 = pops;
      for (int i = 0; i < 100; i++) push_desc(rand_desc(40, 400));
      enable = 1'b1;
      drain(40000);
      chk("b2b_count", 64'(pkt_count), 64'd100);
      chk("b2b_pops", 64'(pops - p0), 64'd100);
      chk("b2b_empty", 64'(fifo_empty), 64'd1);

      // Enable dropped during the second of four frames
      base = frames_done;
      for (int i = 0; i < 4; i++) push_desc(rand_desc(100, 100));
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         cycle();
         if (frames_done == base + 1 && beat_idx == 3) hit = 1'b1;
      end
      chk("en_reach_beat3", 64'(hit), 64'd1);
      enable = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         cycle();
         if (frames_done == base + 2 && !busy) hit = 1'b1;
      end
      chk("en_frame2_done", 64'(hit), 64'd1);
      p0 = pops;
      repeat (30) cycle();
      chk("en_no_pop", 64'(pops), 64'(p0));
      chk("en_busy", 64'(busy), 64'd0);
      chk("en_count", 64'(pkt_count), 64'(base + 2));
      enable = 1'b1;
      drain(1000);

      // Asynchronous reset in the middle of a frame
      for (int i = 0; i < 2; i++) push_desc(rand_desc(200, 200));
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         cycle();
         if (busy && beat_idx == 5) hit = 1'b1;
      end
      chk("ar_reach_mid", 64'(hit), 64'd1);
      pre_edge();
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 64'(tx_valid), 64'd0);
      chk("ar_last", 64'(tx_last), 64'd0);
      chk("ar_data", tx_data, 64'd0);
      chk("ar_keep", 64'(tx_keep), 64'd0);
      chk("ar_count", 64'(pkt_count), 64'd0);
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_rd_en", 64'(fifo_rd_en), 64'd0);
      @(negedge clk);
      monitor();
      repeat (2) cycle();
      rst = 1'b0;
      drain(1000);
      chk("ar_after_count", 64'(pkt_count), 64'd1);
      chk("exp_left", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
